// File: rtl/argo_chan_pkg.sv
// Shared Argo channel definitions: receive-buffer occupancy encoding and
// constants common to argo_fifo and argo_chan_rx.
package argo_chan_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int RD_LATENCY         = 1;

endpackage

// File: rtl/argo_chan_rx.sv
// Argo channel receive adapter: pops argo_fifo, hides its 1-cycle read latency
// and feeds a 2-entry valid/ready output buffer. Optional counters: ARGO_CHAN_RX_STATS_EN.
//
// state | meaning
// EMPTY | no buffered element (a read may be in flight)
// ONE   | buf0 holds the head
// TWO   | buf0 head, buf1 next; no read in flight
module argo_chan_rx
   import argo_chan_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
`ifdef ARGO_CHAN_RX_STATS_EN
   output logic [CNT_WIDTH-1:0]  rx_count,
   output logic [CNT_WIDTH-1:0]  stall_count,
`endif
   output logic [DATA_WIDTH-1:0] out_data
);

   if (RD_LATENCY != 1 || CNT_WIDTH < 1) begin : g_bad_cfg
      $error("argo_chan_rx supports only a 1-cycle FIFO read latency");
   end

   occ_e                  state_q, state_d;
   logic                  pend_q, pend_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic                  pop;
   logic [1:0]            land_idx;
   logic [1:0]            occ_n;

   assign out_valid = (state_q != EMPTY);
   assign out_data  = buf0_q;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         pend_q  <= 1'b0;
         buf0_q  <= '0;
         buf1_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      land_idx   = 2'(state_q) - {1'b0, pop};
      occ_n      = land_idx + {1'b0, pend_q};
      // rst gate keeps the FIFO from being popped while we are held in reset
      fifo_rd_en = !rst && !fifo_empty && (occ_n <= 2'd1);
      pend_d     = fifo_rd_en;

      unique case (state_q)
         EMPTY: if (pend_q) state_d = ONE;
         ONE: begin
            if (pend_q && !pop)      state_d = TWO;
            else if (!pend_q && pop) state_d = EMPTY;
         end
         TWO:     if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase

      if (pop) buf0_d = buf1_q;
      // landing slot is computed after the pop shift, so ONE+pop lands in buf0
      if (pend_q) begin
         if (land_idx == 2'd0) buf0_d = fifo_rd_data;
         else                  buf1_d = fifo_rd_data;
      end
   end

`ifdef ARGO_CHAN_RX_STATS_EN
   logic [CNT_WIDTH-1:0] rx_q, stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q    <= '0;
         stall_q <= '0;
      end else begin
         if (pop)                    rx_q    <= rx_q + 1'b1;
         if (out_valid && !out_ready) stall_q <= stall_q + 1'b1;
      end
   end

   assign rx_count    = rx_q;
   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_argo_chan_rx.sv
// Directed bench for argo_chan_rx against a small behavioural argo_fifo model.
module tb_argo_chan_rx;
   import argo_chan_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [31:0] fifo_rd_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
`ifdef ARGO_CHAN_RX_STATS_EN
   logic [31:0] rx_count, stall_count;
`endif

   logic [31:0] mem [0:2047];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          total  = 0;
   int          bad    = 0;
   logic [31:0] rxq [$];

   argo_chan_rx #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_empty  (fifo_empty),
      .fifo_rd_en  (fifo_rd_en),
      .fifo_rd_data(fifo_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
`ifdef ARGO_CHAN_RX_STATS_EN
      .rx_count    (rx_count),
      .stall_count (stall_count),
`endif
      .out_data    (out_data)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_ptr[10:0]];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   always @(posedge clk) begin
      if (out_valid && out_ready) rxq.push_back(out_data);
   end

   task automatic push(input logic [31:0] d);
      mem[wr_ptr[10:0]] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rxq.delete();
   endtask

   task automatic test_reset();
      bit seen;
      @(negedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
      push(32'h99);
      #1;
      total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         #1;
         if (out_valid) seen = 1;
         else @(negedge clk);
      end
      total++; if (!seen || out_data !== 32'h99) begin bad++; $display("FAIL reset_release_data: got %h valid %b want 00000099", out_data, seen); end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_basic();
      logic [31:0] exp3 [3];
      exp3[0] = 32'h11; exp3[1] = 32'h22; exp3[2] = 32'h33;
      do_reset();
      out_ready = 1'b1;
      push(32'h11); push(32'h22); push(32'h33);
      #1;
      total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL basic_first_rd_en: got %b want 1", fifo_rd_en); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_c0: got %b want 0", out_valid); end
      @(negedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_c1: got %b want 0", out_valid); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || out_data !== exp3[k]) begin
            bad++; $display("FAIL basic_item%0d: got valid %b data %h want valid 1 data %h", k, out_valid, out_data, exp3[k]);
         end
      end
      @(negedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      int n;
      logic [31:0] exp5 [5];
      exp5[0] = 32'h11; exp5[1] = 32'h22; exp5[2] = 32'h33; exp5[3] = 32'h44; exp5[4] = 32'h55;
      do_reset();
      for (int i = 0; i < 5; i++) push(exp5[i]);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (fifo_rd_en) n++;
         @(negedge clk);
      end
      #1;
      total++; if (n != 2) begin bad++; $display("FAIL bp_rd_pulses: got %0d want 2", n); end
      total++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin bad++; $display("FAIL bp_hold_head: got valid %b data %h want 1 00000011", out_valid, out_data); end
      total++; if (dut.state_q !== TWO) begin bad++; $display("FAIL bp_occ: got %0d want 2", dut.state_q); end
      total++; if (wr_ptr - rd_ptr != 3) begin bad++; $display("FAIL bp_fifo_left: got %0d want 3", wr_ptr - rd_ptr); end
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++;
         if (out_valid !== 1'b1 || out_data !== exp5[k]) begin
            bad++; $display("FAIL bp_item%0d: got valid %b data %h want valid 1 data %h", k, out_valid, out_data, exp5[k]);
         end
         @(negedge clk);
      end
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_random();
      int          pushed, cyc, base_rd, inflight;
      logic        prev_stall;
      logic [31:0] prev_data;
      do_reset();
      pushed = 0; cyc = 0; prev_stall = 0; prev_data = '0;
      base_rd = rd_ptr;
      while (rxq.size() < 1000 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (prev_stall) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
               bad++; $display("FAIL rand_stable: got valid %b data %h want 1 %h", out_valid, out_data, prev_data);
            end
         end
         if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
            push(32'hA000_0000 + 32'(pushed));
            pushed++;
         end
         out_ready = ($urandom_range(0, 1) == 1);
         #1;
         total++; if (fifo_rd_en && fifo_empty) begin bad++; $display("FAIL rand_rd_when_empty: got rd_en 1 want 0"); end
         inflight = (rd_ptr - base_rd) - rxq.size();
         total++; if (inflight > 2) begin bad++; $display("FAIL rand_occ_pend: got %0d want <=2", inflight); end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
      total++; if (rxq.size() != 1000) begin bad++; $display("FAIL rand_count: got %0d want 1000", rxq.size()); end
      for (int i = 0; i < rxq.size(); i++) begin
         total++;
         if (rxq[i] !== 32'hA000_0000 + 32'(i)) begin
            bad++; $display("FAIL rand_order[%0d]: got %h want %h", i, rxq[i], 32'hA000_0000 + 32'(i));
         end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midstream();
      bit seen;
      do_reset();
      push(32'h71); push(32'h72); push(32'h73);
      @(negedge clk);
      @(negedge clk);
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== 32'h71) begin bad++; $display("FAIL mid_pre: got valid %b data %h want 1 00000071", out_valid, out_data); end
      rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
      total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rd_en: got %b want 0", fifo_rd_en); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         #1;
         if (out_valid) seen = 1;
         else @(negedge clk);
      end
      total++; if (!seen || out_data !== 32'h73) begin bad++; $display("FAIL mid_next_head: got %h valid %b want 00000073", out_data, seen); end
      @(negedge clk); #1;
      total++; if (rxq.size() != 1 || rxq[0] !== 32'h73) begin bad++; $display("FAIL mid_delivered: got %0d items want 1 item 00000073", rxq.size()); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_drained: got %b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_single();
      int vcnt, rcnt;
      do_reset();
      out_ready = 1'b1;
      push(32'h5A);
      vcnt = 0; rcnt = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (fifo_rd_en) rcnt++;
         if (out_valid) begin
            vcnt++;
            total++; if (out_data !== 32'h5A) begin bad++; $display("FAIL single_data: got %h want 0000005a", out_data); end
         end
         @(negedge clk);
      end
      #1;
      total++; if (vcnt != 1) begin bad++; $display("FAIL single_valid_cycles: got %0d want 1", vcnt); end
      total++; if (rcnt != 1) begin bad++; $display("FAIL single_rd_pulses: got %0d want 1", rcnt); end
      total++; if (dut.state_q !== EMPTY) begin bad++; $display("FAIL single_occ: got %0d want 0", dut.state_q); end
      out_ready = 1'b0;
   endtask

`ifdef ARGO_CHAN_RX_STATS_EN
   task automatic test_stats();
      bit seen;
      int cyc;
      do_reset();
      for (int i = 0; i < 10; i++) push(32'hB0 + 32'(i));
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         #1;
         if (out_valid) seen = 1;
         else @(negedge clk);
      end
      total++; if (!seen) begin bad++; $display("FAIL stats_first_valid: got 0 want 1"); end
      repeat (4) @(negedge clk);
      out_ready = 1'b1;
      cyc = 0;
      while (rxq.size() < 10 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      repeat (2) @(negedge clk);
      #1;
      total++; if (rx_count !== 32'd10) begin bad++; $display("FAIL stats_rx: got %0d want 10", rx_count); end
      total++; if (stall_count !== 32'd4) begin bad++; $display("FAIL stats_stall: got %0d want 4", stall_count); end
      out_ready = 1'b0;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_random();
      test_reset_midstream();
      test_single();
`ifdef ARGO_CHAN_RX_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
